// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the clause 22 MDIO master.
// Frame fields after the preamble: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16).
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PREAMBLE,
    S_START,
    S_OPCODE,
    S_PHYADDR,
    S_REGADDR,
    S_TURNAROUND,
    S_DATA,
    S_DONE
  } mdio_state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int START_LEN   = 2;
  localparam int OPCODE_LEN  = 2;
  localparam int PHYADDR_LEN = 5;
  localparam int REGADDR_LEN = 5;
  localparam int TA_LEN      = 2;
  localparam int DATA_LEN    = 16;
  localparam int DONE_LEN    = 1;
  localparam int FRAME_LEN   = START_LEN + OPCODE_LEN + PHYADDR_LEN + REGADDR_LEN + TA_LEN + DATA_LEN;

  // Preamble length is a module parameter, so it is resolved by the caller.
  function automatic int field_len(mdio_state_t s);
    case (s)
      S_START:      return START_LEN;
      S_OPCODE:     return OPCODE_LEN;
      S_PHYADDR:    return PHYADDR_LEN;
      S_REGADDR:    return REGADDR_LEN;
      S_TURNAROUND: return TA_LEN;
      S_DATA:       return DATA_LEN;
      default:      return DONE_LEN;
    endcase
  endfunction

  function automatic mdio_state_t next_field(mdio_state_t s);
    case (s)
      S_PREAMBLE:   return S_START;
      S_START:      return S_OPCODE;
      S_OPCODE:     return S_PHYADDR;
      S_PHYADDR:    return S_REGADDR;
      S_REGADDR:    return S_TURNAROUND;
      S_TURNAROUND: return S_DATA;
      S_DATA:       return S_DONE;
      default:      return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: one bit period per CLOCK_DIVIDER clks, mdc low then high.
// fall_tick marks the clk where a bit starts (mdc goes low), rise_tick where mdc goes high.
module mdio_clk_gen #(
  parameter int CLOCK_DIVIDER = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic stop,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CNT_W = $clog2(CLOCK_DIVIDER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_DIVIDER - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLOCK_DIVIDER / 2);

  logic [CNT_W-1:0] cnt;

  assign fall_tick = run && (cnt == '0);
  assign rise_tick = run && (cnt == HALF);

  // stop on the final fall tick parks the counter at 0 so a back-to-back
  // command starts its first bit one clk after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      if (!run || (fall_tick && stop) || (cnt == LAST)) cnt <= '0;
      else                                              cnt <= cnt + CNT_W'(1);
      if (!run || fall_tick) mdc <= 1'b0;
      else if (rise_tick)    mdc <= 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: one command at a time, full frame on MDC/MDIO, read data + no-PHY flag.
// Optional MDIO_PREAMBLE_SUPPRESS_EN adds cmd_no_preamble to skip the preamble per command.
module mdio_master #(
  parameter int CLOCK_DIVIDER   = 50,
  parameter int PREAMBLE_LENGTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyaddr,
  input  logic [4:0]  cmd_regaddr,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_no_preamble,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  import mdio_pkg::*;

  if (CLOCK_DIVIDER < 4 || (CLOCK_DIVIDER % 2) != 0) begin : g_bad_divider
    $error("mdio_master: CLOCK_DIVIDER must be even and >= 4");
  end
  if (PREAMBLE_LENGTH < 1) begin : g_bad_preamble
    $error("mdio_master: PREAMBLE_LENGTH must be >= 1");
  end

  localparam int CNT_MAX = (PREAMBLE_LENGTH > DATA_LEN) ? PREAMBLE_LENGTH : DATA_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);

  mdio_state_t          state, state_n, first_state;
  logic [CNT_W-1:0]     bit_cnt, bit_n, last_bit;
  logic                 primed;
  logic                 accept;
  logic                 fall_tick, rise_tick;
  logic                 is_write, err_q;
  logic [FRAME_LEN-1:0] tx_sh;
  logic [15:0]          rdata_sh;
  logic                 drive_o, drive_oe, shift_en;

  // Handshake: a command transfers on a clk where cmd_valid && cmd_ready; cmd_ready is
  // high only in IDLE, so cmd_* are ignored for the whole frame. rsp_valid pulses one clk
  // at the end of DONE, in the same clk cmd_ready returns high.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign first_state = cmd_no_preamble ? S_START : S_PREAMBLE;
`else
  assign first_state = S_PREAMBLE;
`endif

  mdio_clk_gen #(.CLOCK_DIVIDER(CLOCK_DIVIDER)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (state != S_IDLE),
    .stop      (state == S_DONE),
    .mdc       (mdc),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_comb begin
    if (state == S_PREAMBLE) last_bit = CNT_W'(PREAMBLE_LENGTH - 1);
    else                     last_bit = CNT_W'(field_len(state) - 1);
  end

  // state/bit_cnt name the bit currently on the wire; the first fall tick after
  // acceptance starts bit 0 without advancing (primed == 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      primed  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      if (state == S_IDLE) primed <= 1'b0;
      else if (fall_tick)  primed <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    if (state == S_IDLE) begin
      if (accept) begin
        state_n = first_state;
        bit_n   = '0;
      end
    end else if (fall_tick && primed) begin
      if (bit_cnt == last_bit) begin
        state_n = next_field(state);
        bit_n   = '0;
      end else begin
        bit_n = bit_cnt + CNT_W'(1);
      end
    end
  end

  // Pad drive for the bit that starts at the next fall tick.
  always_comb begin
    drive_o  = 1'b1;
    drive_oe = 1'b0;
    shift_en = 1'b0;
    case (state_n)
      S_PREAMBLE: drive_oe = 1'b1;
      S_START, S_OPCODE, S_PHYADDR, S_REGADDR: begin
        drive_o  = tx_sh[FRAME_LEN-1];
        drive_oe = 1'b1;
        shift_en = 1'b1;
      end
      S_TURNAROUND, S_DATA: begin
        drive_o  = tx_sh[FRAME_LEN-1];
        drive_oe = is_write;
        shift_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write  <= 1'b0;
      err_q     <= 1'b0;
      tx_sh     <= '0;
      rdata_sh  <= '0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        is_write <= cmd_write;
        err_q    <= 1'b0;
        // Read frames carry idle ones in TA/DATA; they are never driven (oe=0).
        tx_sh    <= cmd_write ? {ST, OP_WRITE, cmd_phyaddr, cmd_regaddr, TA_WRITE, cmd_wdata}
                              : {ST, OP_READ, cmd_phyaddr, cmd_regaddr, 2'b11, 16'hFFFF};
      end
      if (fall_tick) begin
        mdio_o  <= drive_o;
        mdio_oe <= drive_oe;
        if (shift_en) tx_sh <= tx_sh << 1;
      end
      if (rise_tick) begin
        if (state == S_TURNAROUND && bit_cnt == CNT_W'(1) && !is_write) err_q <= mdio_i;
        if (state == S_DATA) rdata_sh <= {rdata_sh[14:0], mdio_i};
      end
      if (fall_tick && state == S_DONE && state_n == S_IDLE) begin
        rsp_valid <= 1'b1;
        rsp_error <= !is_write && err_q;
        if (!is_write) rsp_rdata <= rdata_sh;
      end
    end
  end

endmodule
